pager_mmu: RTL and testbench
============================

Name: pager_mmu

Overview:
- Parametrised successor to the single-window page selector and external-SRAM glue in the 6801 SoC top level.
- Provides NUM_WIN independent 8 KB bank windows, each with its own page register and write-protect bit.
- Includes a programmable wait-state sequencer that stalls the CPU via hold for slow external memory, and flags and optionally interrupts on writes to protected windows.
- Sits between cpu68 and the external SRAM pins. The CPU sees it as a register block in the $E6E0 decode slot.

Parameters:
- NUM_WIN, 4: number of bank windows; 1..(8-FIRST_SLOT).
- FIRST_SLOT, 4: 8 KB CPU slot (AD[15:13]) mapped by window 0. Window i maps slot FIRST_SLOT+i.
- PAGE_BITS, 3: page number width; must be >=3.
- EXT_AW, PAGE_BITS+14: external address width.

Ports:
- clk  in  1  CPU clock (sys_clk domain)
- rst  in  1  asynchronous, active-low reset
- AD  in  16  CPU address
- DI  in  8  CPU write data
- DO  out  8  register read data
- rw  in  1  1 = read, 0 = write
- vma  in  1  CPU valid memory address
- cs  in  1  register-block select (already qualified with vma); uses AD[3:0]
- ext_sel  in  1  top-level decode: cycle targets external memory
- hold  out  1  CPU stall request
- irq  out  1  protection-violation interrupt, level
- ext_ad  out  EXT_AW  external address
- ext_ce  out  1  SRAM chip enable, active-high
- ext_oe_n  out  1  output enable, active-low
- ext_we_n  out  1  write enable, active-low

Behaviour:
- Register map (AD[3:0]); unimplemented offsets read $FF and ignore writes:
  - 0..NUM_WIN-1 PAGEi: [PAGE_BITS-1:0] page, bit6 WP, bit7 EN. Unused bits read 0.
  - 8 CTRL: [2:0] wait states W, bit6 IRQ enable, bit7 global enable GEN.
  - 9 STAT: bit0 VIOL (sticky; write 1 clears), bit1 BUSY (state != IDLE). Other bits read 0.
- Register writes take effect at the rising clk edge where cs && !rw. Reads are combinational.
- Mapping:
  - Window i hits when GEN && PAGEi.EN && AD[15:13]==FIRST_SLOT+i.
  - On a hit: ext_ad = {1'b1, page, AD[12:0]}.
  - Otherwise: ext_ad = zero-extended {1'b0, AD}.
  - ext_ad is combinational.
- Protected write: a hit with WP=1 and rw=0.
  - ext_we_n stays high for the whole cycle.
  - VIOL is set at the end of the access.
  - The cycle still completes, including wait states.
- Sequencer, defined by ext_req = ext_sel && vma:
  - IDLE:
    - If ext_req && W==0, this is the access cycle; no hold.
    - If ext_req && W!=0: hold=1, load cnt=W, go to WAIT.
  - WAIT:
    - hold=1, cnt decrements each cycle.
    - When cnt==1, go to ACCESS.
  - ACCESS: hold=0; access cycle; next state IDLE.
  - Total latency: W+1 clocks per external access.
- Strobes:
  - ext_ce = ext_req.
  - ext_oe_n and ext_we_n are low only in the access cycle, during the low half of clk (gated by ~clk), matching existing SRAM timing.
  - oe_n when rw=1; we_n when rw=0 and the write is not protected.
- irq = VIOL && CTRL.bit6.
- Simultaneous events:
  - A violation and a STAT write-1-clear in the same cycle: set wins.
  - ext_req dropping while in WAIT: return to IDLE, hold=0.
  - W changed during WAIT: no effect on the current count.
- Reset (async, rst low), all values immediate:
  - All PAGE regs 0; CTRL 0; VIOL 0; state IDLE; cnt 0.
  - hold 0, irq 0, ext_ce 0, ext_oe_n 1, ext_we_n 1.
  - Reset during WAIT aborts the access with no strobes.

Test Plan:
- Reset values: assert rst=0 mid-WAIT with W=3 -> hold, irq, ext_ce drop immediately. Registers read back: PAGE0=$00, CTRL=$00, STAT=$00.
- Mapping: write PAGE1=$85, CTRL=$80, then read AD=$A123 -> ext_ad=$1A123 (page 5, slot 5). AD=$C123 (PAGE2.EN=0) -> ext_ad=$0C123.
- Wait states: CTRL=$83, external read -> hold high exactly 3 clocks, oe_n low in the 4th clock's low phase only. With W=0, hold never asserts.
- Write protect: PAGE0=$C2, CTRL=$C0, write to $8010 -> ext_we_n stays 1, STAT=$01, irq=1. Write STAT=$01 -> irq=0. Repeat with a violation and the clear in the same cycle -> VIOL remains 1.
- Register decode: read offsets $A-$F and offsets >= NUM_WIN below 8 -> $FF. Writes to them leave all registers unchanged.
- Parameters: instantiate NUM_WIN=2, FIRST_SLOT=6, PAGE_BITS=4 -> AD=$E000 with PAGE1=$8F gives ext_ad=$3E000 (EXT_AW=18). AD=$8000 is unmapped.

Source files
------------

// File: rtl/pager_mmu.sv
// Banked memory manager for the 6801 SoC: NUM_WIN 8 KB windows into a larger
// external SRAM, a wait-state sequencer that stalls the CPU, and write protection.
module pager_mmu #(
    parameter int NUM_WIN    = 4,
    parameter int FIRST_SLOT = 4,
    parameter int PAGE_BITS  = 3,
    parameter int EXT_AW     = PAGE_BITS + 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       AD,
    input  logic [7:0]        DI,
    output logic [7:0]        DO,
    input  logic              rw,
    input  logic              vma,
    input  logic              cs,
    input  logic              ext_sel,
    output logic              hold,
    output logic              irq,
    output logic [EXT_AW-1:0] ext_ad,
    output logic              ext_ce,
    output logic              ext_oe_n,
    output logic              ext_we_n
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    logic [PAGE_BITS-1:0] page_q [NUM_WIN];
    logic [PAGE_BITS-1:0] page_d [NUM_WIN];
    logic [NUM_WIN-1:0]   wp_q, wp_d;
    logic [NUM_WIN-1:0]   en_q, en_d;
    logic [2:0]           wait_q, wait_d;
    logic                 irqen_q, irqen_d;
    logic                 gen_q, gen_d;
    logic                 viol_q, viol_d;
    state_t               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;

    logic                 reg_wr;
    logic [3:0]           off;
    logic                 ext_req;
    logic                 hit;
    logic [PAGE_BITS-1:0] hit_page;
    logic                 hit_wp;
    logic                 prot_wr;
    logic                 hold_c;
    logic                 acc;
    logic                 acc_g;
    logic                 unused_di;

    assign reg_wr    = cs && !rw;
    assign off       = AD[3:0];
    assign ext_req   = ext_sel && vma;
    assign unused_di = ^DI;

    // Register file write path
    always_comb begin
        page_d  = page_q;
        wp_d    = wp_q;
        en_d    = en_q;
        wait_d  = wait_q;
        irqen_d = irqen_q;
        gen_d   = gen_q;
        if (reg_wr) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (off == 4'(i)) begin
                    page_d[i] = DI[PAGE_BITS-1:0];
                    wp_d[i]   = DI[6];
                    en_d[i]   = DI[7];
                end
            end
            if (off == 4'd8) begin
                wait_d  = DI[2:0];
                irqen_d = DI[6];
                gen_d   = DI[7];
            end
        end
    end

    // Window match; slots are distinct, so at most one window can hit
    always_comb begin
        hit      = 1'b0;
        hit_page = '0;
        hit_wp   = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (gen_q && en_q[i] && (AD[15:13] == 3'(FIRST_SLOT + i))) begin
                hit      = 1'b1;
                hit_page = page_q[i];
                hit_wp   = wp_q[i];
            end
        end
        if (hit) begin
            ext_ad = EXT_AW'({1'b1, hit_page, AD[12:0]});
        end else begin
            ext_ad = EXT_AW'({1'b0, AD});
        end
    end

    assign prot_wr = hit && hit_wp && !rw;

    // Wait-state sequencer: the IDLE cycle counts as the first held clock
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_c  = 1'b0;
        acc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ext_req) begin
                    if (wait_q == 3'd0) begin
                        acc = 1'b1;
                    end else begin
                        hold_c  = 1'b1;
                        cnt_d   = wait_q;
                        state_d = (cnt_d == 3'd1) ? S_ACCESS : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!ext_req) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    hold_c = 1'b1;
                    cnt_d  = cnt_q - 3'd1;
                    if (cnt_d == 3'd1) begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                acc     = ext_req;
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        viol_d = viol_q;
        if (reg_wr && (off == 4'd9) && DI[0]) begin
            viol_d = 1'b0;
        end
        if (acc && prot_wr) begin
            viol_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                page_q[i] <= '0;
            end
            wp_q    <= '0;
            en_q    <= '0;
            wait_q  <= 3'd0;
            irqen_q <= 1'b0;
            gen_q   <= 1'b0;
            viol_q  <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_WIN; i++) begin
                page_q[i] <= page_d[i];
            end
            wp_q    <= wp_d;
            en_q    <= en_d;
            wait_q  <= wait_d;
            irqen_q <= irqen_d;
            gen_q   <= gen_d;
            viol_q  <= viol_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced inactive while reset is held, even mid-access
    assign acc_g    = acc && rst;
    assign hold     = hold_c && rst;
    assign ext_ce   = ext_req && rst;
    assign irq      = viol_q && irqen_q;
    assign ext_oe_n = !(acc_g && rw && !clk);
    assign ext_we_n = !(acc_g && !rw && !prot_wr && !clk);

    always_comb begin
        DO = 8'hFF;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (off == 4'(i)) begin
                DO                = 8'h00;
                DO[PAGE_BITS-1:0] = page_q[i];
                DO[6]             = wp_q[i];
                DO[7]             = en_q[i];
            end
        end
        if (off == 4'd8) begin
            DO = {gen_q, irqen_q, 3'b000, wait_q};
        end
        if (off == 4'd9) begin
            DO = {6'b000000, (state_q != S_IDLE), viol_q};
        end
    end

endmodule

// File: tb/tb_pager_mmu.sv
// Directed bench for pager_mmu: stimulus queues expected values, a monitor
// samples the DUT outputs and compares them.
module tb_pager_mmu;

    localparam int K_DO   = 0;
    localparam int K_AD   = 1;
    localparam int K_HOLD = 2;
    localparam int K_IRQ  = 3;
    localparam int K_CE   = 4;
    localparam int K_OE   = 5;
    localparam int K_WE   = 6;
    localparam int K_DO2  = 7;
    localparam int K_AD2  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] AD = 16'h0000;
    logic [7:0]  DI = 8'h00;
    logic        rw = 1'b1;
    logic        vma = 1'b0;
    logic        cs = 1'b0;
    logic        ext_sel = 1'b0;

    logic [7:0]  DO, DO2;
    logic        hold, irq, ext_ce, ext_oe_n, ext_we_n;
    logic        hold2, irq2, ext_ce2, ext_oe_n2, ext_we_n2;
    logic [16:0] ext_ad;
    logic [17:0] ext_ad2;

    pager_mmu dut (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .vma(vma),
        .cs(cs), .ext_sel(ext_sel), .hold(hold), .irq(irq), .ext_ad(ext_ad),
        .ext_ce(ext_ce), .ext_oe_n(ext_oe_n), .ext_we_n(ext_we_n)
    );

    pager_mmu #(.NUM_WIN(2), .FIRST_SLOT(6), .PAGE_BITS(4)) dut2 (
        .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO2), .rw(rw), .vma(vma),
        .cs(cs), .ext_sel(ext_sel), .hold(hold2), .irq(irq2), .ext_ad(ext_ad2),
        .ext_ce(ext_ce2), .ext_oe_n(ext_oe_n2), .ext_we_n(ext_we_n2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        bit          hi;
        string       name;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int kind, input logic [31:0] exp, input string name,
                        input bit hi = 1'b0);
        chk_t e;
        e.kind = kind;
        e.exp  = exp;
        e.hi   = hi;
        e.name = name;
        q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_DO:    return 32'(DO);
            K_AD:    return 32'(ext_ad);
            K_HOLD:  return 32'(hold);
            K_IRQ:   return 32'(irq);
            K_CE:    return 32'(ext_ce);
            K_OE:    return 32'(ext_oe_n);
            K_WE:    return 32'(ext_we_n);
            K_DO2:   return 32'(DO2);
            K_AD2:   return 32'(ext_ad2);
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic compare(input chk_t e);
        logic [31:0] got;
        got = observe(e.kind);
        checks++;
        if (got !== e.exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", e.name, got, e.exp, $time);
        end
    endtask

    // Monitor: high-phase checks shortly after the rising edge, the rest in the low phase
    initial begin
        chk_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].hi) begin
                e = q.pop_front();
                compare(e);
            end
            @(negedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                compare(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, %0d checks pending", q.size());
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cs      = 1'b0;
        rw      = 1'b1;
        vma     = 1'b0;
        ext_sel = 1'b0;
        DI      = 8'h00;
    endtask

    task automatic wr_reg(input logic [3:0] off, input logic [7:0] val);
        AD = {12'hE6E, off};
        DI = val;
        rw = 1'b0;
        cs = 1'b1;
        vma = 1'b1;
        ext_sel = 1'b0;
        cyc();
        bus_idle();
    endtask

    task automatic rd_chk(input logic [3:0] off, input logic [7:0] exp, input string name);
        AD = {12'hE6E, off};
        rw = 1'b1;
        cs = 1'b1;
        vma = 1'b1;
        ext_sel = 1'b0;
        push(K_DO, 32'(exp), name);
        cyc();
        bus_idle();
    endtask

    task automatic rd_chk2(input logic [3:0] off, input logic [7:0] exp1,
                           input logic [7:0] exp2, input string name);
        AD = {12'hE6E, off};
        rw = 1'b1;
        cs = 1'b1;
        vma = 1'b1;
        ext_sel = 1'b0;
        push(K_DO, 32'(exp1), {name, "_w4"});
        push(K_DO2, 32'(exp2), {name, "_w2"});
        cyc();
        bus_idle();
    endtask

    task automatic ext_start(input logic [15:0] addr, input logic rd);
        AD = addr;
        rw = rd;
        DI = 8'h55;
        cs = 1'b0;
        vma = 1'b1;
        ext_sel = 1'b1;
    endtask

    initial begin
        int n;
        cyc();
        // Outputs while reset is held, with an external write requested
        ext_start(16'h8010, 1'b0);
        push(K_CE, 0, "rst_ce");
        push(K_HOLD, 0, "rst_hold");
        push(K_IRQ, 0, "rst_irq");
        push(K_OE, 1, "rst_oe_n");
        push(K_WE, 1, "rst_we_n");
        cyc();
        bus_idle();
        rst = 1'b1;
        cyc();
        rd_chk(4'd0, 8'h00, "init_page0");
        rd_chk(4'd8, 8'h00, "init_ctrl");

        // Protected write with W=3: full wait sequence, VIOL set at the end
        wr_reg(4'd0, 8'hC2);
        wr_reg(4'd8, 8'hC3);
        ext_start(16'h8010, 1'b0);
        push(K_HOLD, 1, "wp3_hold0");
        push(K_CE, 1, "wp3_ce");
        push(K_AD, 32'h14010, "wp3_ext_ad");
        cyc();
        push(K_HOLD, 1, "wp3_hold1");
        cyc();
        push(K_HOLD, 1, "wp3_hold2");
        cyc();
        push(K_HOLD, 0, "wp3_hold_acc");
        push(K_WE, 1, "wp3_we_n");
        push(K_IRQ, 0, "wp3_irq_before");
        cyc();
        bus_idle();
        push(K_IRQ, 1, "wp3_irq_after");
        rd_chk(4'd9, 8'h01, "wp3_stat");

        // Reset in the middle of a wait sequence
        ext_start(16'h8000, 1'b1);
        push(K_HOLD, 1, "mid_hold0");
        cyc();
        push(K_HOLD, 1, "mid_hold1");
        push(K_CE, 1, "mid_ce");
        push(K_IRQ, 1, "mid_irq");
        cyc();
        rst = 1'b0;
        push(K_HOLD, 0, "mid_rst_hold");
        push(K_CE, 0, "mid_rst_ce");
        push(K_IRQ, 0, "mid_rst_irq");
        push(K_OE, 1, "mid_rst_oe_n");
        cyc();
        bus_idle();
        rst = 1'b1;
        cyc();
        rd_chk(4'd0, 8'h00, "mid_page0");
        rd_chk(4'd8, 8'h00, "mid_ctrl");
        rd_chk(4'd9, 8'h00, "mid_stat");

        // Mapping
        wr_reg(4'd1, 8'h85);
        wr_reg(4'd8, 8'h80);
        AD = 16'hA123;
        push(K_AD, 32'h1A123, "map_hit_a123");
        cyc();
        AD = 16'hC123;
        push(K_AD, 32'h0C123, "map_miss_c123");
        cyc();
        rd_chk(4'd1, 8'h85, "page1_rb");
        wr_reg(4'd2, 8'hFF);
        rd_chk(4'd2, 8'hC7, "page2_unused_bits");
        AD = 16'hC123;
        push(K_AD, 32'h1E123, "map_hit_c123");
        cyc();
        wr_reg(4'd2, 8'h00);

        // Three wait states on a read
        wr_reg(4'd8, 8'h83);
        ext_start(16'hA123, 1'b1);
        push(K_HOLD, 1, "w3_hold0");
        push(K_OE, 1, "w3_oe0");
        cyc();
        push(K_HOLD, 1, "w3_hold1");
        push(K_OE, 1, "w3_oe1");
        cyc();
        push(K_HOLD, 1, "w3_hold2");
        push(K_OE, 1, "w3_oe2");
        cyc();
        push(K_OE, 1, "w3_oe_high_phase", 1'b1);
        push(K_HOLD, 0, "w3_hold_acc");
        push(K_OE, 0, "w3_oe_acc");
        push(K_WE, 1, "w3_we_acc");
        push(K_AD, 32'h1A123, "w3_ext_ad");
        cyc();
        bus_idle();
        push(K_HOLD, 0, "w3_hold_after");
        push(K_OE, 1, "w3_oe_after");
        cyc();

        // Request dropped during WAIT; STAT.BUSY observed
        ext_start(16'hA129, 1'b1);
        cs = 1'b1;
        push(K_DO, 32'h00, "stat_idle");
        push(K_HOLD, 1, "drop_hold0");
        cyc();
        push(K_DO, 32'h02, "stat_busy");
        push(K_HOLD, 1, "drop_hold1");
        cyc();
        bus_idle();
        push(K_HOLD, 0, "drop_hold_off");
        push(K_OE, 1, "drop_oe_n");
        cyc();
        rd_chk(4'd9, 8'h00, "stat_after_drop");

        // Zero wait states: access in the first cycle
        wr_reg(4'd8, 8'h80);
        ext_start(16'hA123, 1'b1);
        push(K_HOLD, 0, "w0_rd_hold");
        push(K_OE, 0, "w0_rd_oe");
        cyc();
        ext_start(16'hA000, 1'b0);
        push(K_HOLD, 0, "w0_wr_hold");
        push(K_WE, 0, "w0_wr_we");
        push(K_OE, 1, "w0_wr_oe");
        cyc();
        bus_idle();

        // Write protect, clear, and simultaneous set/clear
        wr_reg(4'd0, 8'hC2);
        wr_reg(4'd8, 8'hC0);
        ext_start(16'h8010, 1'b0);
        push(K_HOLD, 0, "wp_hold");
        push(K_WE, 1, "wp_we_n");
        push(K_CE, 1, "wp_ce");
        cyc();
        bus_idle();
        push(K_IRQ, 1, "wp_irq");
        rd_chk(4'd9, 8'h01, "wp_stat");
        wr_reg(4'd9, 8'h01);
        push(K_IRQ, 0, "clr_irq");
        rd_chk(4'd9, 8'h00, "clr_stat");
        ext_start(16'h8019, 1'b0);
        DI = 8'h01;
        cs = 1'b1;
        push(K_WE, 1, "simul_we_n");
        cyc();
        bus_idle();
        push(K_IRQ, 1, "simul_irq");
        rd_chk(4'd9, 8'h01, "simul_stat");

        // Unimplemented offsets
        for (int o = 4; o < 16; o++) begin
            if (o < 8 || o > 9) rd_chk(4'(o), 8'hFF, $sformatf("rd_off%0h", o));
        end
        for (int o = 4; o < 16; o++) begin
            if (o < 8 || o > 9) wr_reg(4'(o), 8'h00);
        end
        rd_chk(4'd0, 8'hC2, "keep_page0");
        rd_chk(4'd1, 8'h85, "keep_page1");
        rd_chk(4'd8, 8'hC0, "keep_ctrl");
        rd_chk(4'd9, 8'h01, "keep_stat");

        // Second parameter set
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        wr_reg(4'd1, 8'h8F);
        wr_reg(4'd8, 8'h80);
        AD = 16'hE000;
        push(K_AD2, 32'h3E000, "p2_hit_e000");
        push(K_AD, 32'h0E000, "p1_miss_e000");
        cyc();
        AD = 16'h8000;
        push(K_AD2, 32'h08000, "p2_miss_8000");
        cyc();
        AD = 16'hC000;
        push(K_AD2, 32'h0C000, "p2_miss_c000");
        cyc();
        rd_chk2(4'd1, 8'h87, 8'h8F, "page1_width");
        rd_chk2(4'd2, 8'h00, 8'hFF, "off2");

        repeat (2) cyc();
        n = 0;
        while (q.size() > 0 && n < 20) begin
            cyc();
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d checks left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
